// File: rtl/rgb_pwm_bank.sv
// rgb_pwm_bank
// ------------------------------------------------------------------------
// Multi-channel RGB brightness controller. Each of the CH RGB LEDs has one
// duty register per colour. Debounced up/down presses move the register
// addressed by {ch_sel, sel} in saturating STEP increments. A shared,
// prescaled counter turns every duty into a PWM waveform.
//
// Optional feature: define AUTO_REPEAT_EN to get auto-repeat on a held
// up/down button. The first repeat comes REPEAT_DLY cycles after the press,
// and later repeats come every REPEAT_PER cycles. Without the macro no
// repeat hardware is built.
//
// Ports
//   clk       system clock (only clock domain)
//   rst       synchronous, active-high reset
//   btn_up    debounced level, press raises brightness
//   btn_dn    debounced level, press lowers brightness
//   btn_show  debounced level, press toggles output enable
//   sel       colour select: 00 none, 01 R, 10 G, 11 B
//   ch_sel    channel select, values >= CH are ignored
//   pwm_r/g/b registered PWM outputs, one bit per channel, gated by enable
//   led_mon   registered raw PWM of the selected channel/colour (ungated)
//   duty_o    combinational duty of the selected channel/colour
// ------------------------------------------------------------------------
module rgb_pwm_bank #(
    parameter int CH         = 2,
    parameter int DUTY_W     = 8,
    parameter int STEP       = 10,
    parameter int PRESC      = 1,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000,
    localparam int CSW       = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_show,
    input  logic [1:0]        sel,
    input  logic [CSW-1:0]    ch_sel,
    output logic [CH-1:0]     pwm_r,
    output logic [CH-1:0]     pwm_g,
    output logic [CH-1:0]     pwm_b,
    output logic              led_mon,
    output logic [DUTY_W-1:0] duty_o
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [DUTY_W-1:0] MAX    = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] UP_LIM = MAX - STEP_V;

    function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d);
        return (d > UP_LIM) ? MAX : d + STEP_V;
    endfunction

    function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] d);
        return (d < STEP_V) ? '0 : d - STEP_V;
    endfunction

    logic [2:0]        btn;
    logic [2:0]        btn_q;
    logic [2:0]        blocked;
    logic [2:0]        press;
    logic              press_up;
    logic              press_dn;
    logic              press_show;
    logic              step_up;
    logic              step_dn;
    logic              addr_ok;
    logic [1:0]        col;
    logic [DUTY_W-1:0] duty [CH][3];
    logic              en;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [DUTY_W-1:0] cnt;
    logic [CH-1:0]     raw_r;
    logic [CH-1:0]     raw_g;
    logic [CH-1:0]     raw_b;

    assign btn = {btn_show, btn_dn, btn_up};

    // A press is a rising edge of the level. A button that was already high
    // at reset stays blocked until it is released. This means that holding
    // a button through reset never counts as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= '0;
            blocked <= btn;
        end else begin
            btn_q   <= btn;
            blocked <= blocked & btn;
        end
    end

    assign press      = btn & ~btn_q & ~blocked;
    assign press_up   = press[0];
    assign press_dn   = press[1];
    assign press_show = press[2];

    assign addr_ok = (sel != 2'b00) && (int'(ch_sel) < CH);
    assign col     = sel - 2'd1;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic           rep_arm;
    logic           rep_up;
    logic           rep_phase;
    logic [RW-1:0]  rep_cnt;
    logic [1:0]     sel_q;
    logic [CSW-1:0] ch_sel_q;
    logic           hold_ok;
    logic           rep_fire;

    // The hold is valid only while the armed button stays high, the other
    // button stays low, and the address has not moved since the last cycle.
    always_comb begin
        hold_ok  = rep_arm
                 && (rep_up ? (btn_up & ~btn_dn) : (btn_dn & ~btn_up))
                 && (sel == sel_q) && (ch_sel == ch_sel_q);
        rep_fire = hold_ok
                 && (rep_cnt == (rep_phase ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1)));
    end

    // A single up or down press arms the repeater and restarts the count.
    // The count first runs up to REPEAT_DLY. After the first fire it runs
    // up to REPEAT_PER.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_arm   <= 1'b0;
            rep_up    <= 1'b0;
            rep_phase <= 1'b0;
            rep_cnt   <= '0;
            sel_q     <= '0;
            ch_sel_q  <= '0;
        end else begin
            sel_q    <= sel;
            ch_sel_q <= ch_sel;
            if (press_up ^ press_dn) begin
                rep_arm   <= 1'b1;
                rep_up    <= press_up;
                rep_phase <= 1'b0;
                rep_cnt   <= '0;
            end else if (!hold_ok) begin
                rep_arm   <= 1'b0;
                rep_phase <= 1'b0;
                rep_cnt   <= '0;
            end else if (rep_fire) begin
                rep_phase <= 1'b1;
                rep_cnt   <= '0;
            end else begin
                rep_cnt   <= rep_cnt + RW'(1);
            end
        end
    end

    assign step_up = (press_up & ~press_dn) | (rep_fire & rep_up);
    assign step_dn = (press_dn & ~press_up) | (rep_fire & ~rep_up);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DLY > 0) ^ (REPEAT_PER > 0);

    assign step_up = press_up & ~press_dn;
    assign step_dn = press_dn & ~press_up;
`endif

    // Only the addressed register moves. When up and down are pressed
    // together they cancel, because the step signals already exclude each
    // other.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    duty[c][k] <= '0;
                end
            end
        end else if (addr_ok) begin
            if (step_up) begin
                duty[ch_sel][col] <= sat_up(duty[ch_sel][col]);
            end else if (step_dn) begin
                duty[ch_sel][col] <= sat_dn(duty[ch_sel][col]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
        end else if (press_show) begin
            en <= ~en;
        end
    end

    // The prescaler divides the clock down to one counter tick every PRESC
    // cycles. The PWM counter then wraps naturally from MAX to 0.
    assign tick = (presc == PW'(PRESC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                cnt <= cnt + DUTY_W'(1);
            end
        end
    end

    always_comb begin
        duty_o = '0;
        if (addr_ok) begin
            duty_o = duty[ch_sel][col];
        end
    end

    always_comb begin
        raw_r = '0;
        raw_g = '0;
        raw_b = '0;
        for (int c = 0; c < CH; c++) begin
            raw_r[c] = cnt < duty[c][0];
            raw_g[c] = cnt < duty[c][1];
            raw_b[c] = cnt < duty[c][2];
        end
    end

    // led_mon is not gated by en, so the selected waveform can be watched
    // while the LEDs themselves are dark. duty_o is already 0 for an
    // invalid address, which keeps led_mon low in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r   <= '0;
            pwm_g   <= '0;
            pwm_b   <= '0;
            led_mon <= 1'b0;
        end else begin
            pwm_r   <= en ? raw_r : '0;
            pwm_g   <= en ? raw_g : '0;
            pwm_b   <= en ? raw_b : '0;
            led_mon <= cnt < duty_o;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_bank.sv
// tb_rgb_pwm_bank
// ------------------------------------------------------------------------
// Testbench for rgb_pwm_bank. It builds two instances:
//   dut_a: CH=2, STEP=10, PRESC=1 (the reference configuration)
//   dut_b: CH=3, STEP=7,  PRESC=3 (adds an invalid ch_sel=3 and a prescaler)
// Both instances share the clock, reset, buttons and sel. Each instance has
// its own ch_sel.
//
// A behavioural model follows the rules in plain arithmetic:
//   - the counter value is derived from the cycle count since reset;
//   - duties are stored in integer arrays.
// Every cycle, all outputs of both instances are compared against this
// model. Table vectors and hand-written sequences add fixed expected values.
// When AUTO_REPEAT_EN is defined, the model and the bench also cover the
// auto-repeat feature.
// ------------------------------------------------------------------------
module tb_rgb_pwm_bank;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_show;
    logic [1:0] sel;
    logic       ch_sel_a;
    logic [1:0] ch_sel_b;

    logic [1:0] pwm_r_a, pwm_g_a, pwm_b_a;
    logic       led_mon_a;
    logic [7:0] duty_o_a;
    logic [2:0] pwm_r_b, pwm_g_b, pwm_b_b;
    logic       led_mon_b;
    logic [7:0] duty_o_b;

    int checks;
    int failures;

    rgb_pwm_bank #(.CH(2), .DUTY_W(8), .STEP(10), .PRESC(1),
                   .REPEAT_DLY(20), .REPEAT_PER(5)) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_show(btn_show), .sel(sel), .ch_sel(ch_sel_a),
        .pwm_r(pwm_r_a), .pwm_g(pwm_g_a), .pwm_b(pwm_b_a),
        .led_mon(led_mon_a), .duty_o(duty_o_a)
    );

    rgb_pwm_bank #(.CH(3), .DUTY_W(8), .STEP(7), .PRESC(3),
                   .REPEAT_DLY(20), .REPEAT_PER(5)) dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .btn_show(btn_show), .sel(sel), .ch_sel(ch_sel_b),
        .pwm_r(pwm_r_b), .pwm_g(pwm_g_b), .pwm_b(pwm_b_b),
        .led_mon(led_mon_b), .duty_o(duty_o_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_duty [2][3][3];
    bit         m_en [2];
    bit         m_prev_up, m_prev_dn, m_prev_show;
    int         m_n;
    bit         m_arm [2];
    bit         m_arm_up [2];
    int         m_hold [2];
    logic [1:0] m_last_sel;
    int         m_last_ch [2];
    logic [2:0] e_r [2];
    logic [2:0] e_g [2];
    logic [2:0] e_b [2];
    logic       e_led [2];

    function automatic int nch(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int step_of(input int k);
        return (k == 0) ? 10 : 7;
    endfunction

    function automatic int presc_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit addr_ok(input int k, input logic [1:0] s, input int c);
        return (s != 2'b00) && (c < nch(k));
    endfunction

    function automatic int cur_duty(input int k, input logic [1:0] s, input int c);
        if (!addr_ok(k, s, c)) return 0;
        return m_duty[k][c][int'(s) - 1];
    endfunction

    task automatic model_step(input int k, input bit up_dir, input logic [1:0] s, input int c);
        int d;
        if (addr_ok(k, s, c)) begin
            d = m_duty[k][c][int'(s) - 1];
            if (up_dir) d = (d + step_of(k) > 255) ? 255 : d + step_of(k);
            else        d = (d < step_of(k)) ? 0 : d - step_of(k);
            m_duty[k][c][int'(s) - 1] = d;
        end
    endtask

    task automatic model_edge(input bit r, input bit up, input bit dn, input bit show,
                              input logic [1:0] s, input int ca, input int cb);
        int  chs [2];
        int  cnt;
        bit  pu, pd, ps;
        chs[0] = ca;
        chs[1] = cb;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 3; c++)
                    for (int j = 0; j < 3; j++) m_duty[k][c][j] = 0;
                m_en[k] = 0; m_arm[k] = 0; m_hold[k] = 0; m_last_ch[k] = 0;
                e_r[k] = '0; e_g[k] = '0; e_b[k] = '0; e_led[k] = 1'b0;
            end
            m_prev_up = up; m_prev_dn = dn; m_prev_show = show;
            m_n = 0;
            m_last_sel = 2'b00;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            cnt = (m_n / presc_of(k)) % 256;
            for (int c = 0; c < 3; c++) begin
                e_r[k][c] = (c < nch(k)) && m_en[k] && (cnt < m_duty[k][c][0]);
                e_g[k][c] = (c < nch(k)) && m_en[k] && (cnt < m_duty[k][c][1]);
                e_b[k][c] = (c < nch(k)) && m_en[k] && (cnt < m_duty[k][c][2]);
            end
            e_led[k] = cnt < cur_duty(k, s, chs[k]);
        end
        m_n++;
        pu = up && !m_prev_up;
        pd = dn && !m_prev_dn;
        ps = show && !m_prev_show;
        for (int k = 0; k < 2; k++) begin
`ifdef AUTO_REPEAT_EN
            if (m_arm[k]) begin
                if ((m_arm_up[k] ? (up && !dn) : (dn && !up))
                    && s == m_last_sel && chs[k] == m_last_ch[k]) begin
                    m_hold[k]++;
                    if (m_hold[k] == 20 || (m_hold[k] > 20 && (m_hold[k] - 20) % 5 == 0))
                        model_step(k, m_arm_up[k], s, chs[k]);
                end else begin
                    m_arm[k] = 0;
                    m_hold[k] = 0;
                end
            end
`endif
            if (pu && !pd) model_step(k, 1'b1, s, chs[k]);
            else if (pd && !pu) model_step(k, 1'b0, s, chs[k]);
            if (pu != pd) begin
                m_arm[k] = 1; m_arm_up[k] = pu; m_hold[k] = 0;
            end
            if (ps) m_en[k] = !m_en[k];
            m_last_ch[k] = chs[k];
        end
        m_last_sel = s;
        m_prev_up = up; m_prev_dn = dn; m_prev_show = show;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] act, exp;
        act = 32'({pwm_r_a, pwm_g_a, pwm_b_a, led_mon_a, duty_o_a});
        exp = 32'({e_r[0][1:0], e_g[0][1:0], e_b[0][1:0], e_led[0],
                   8'(cur_duty(0, sel, int'(ch_sel_a)))});
        check_output("model_a", act, exp);
        act = 32'({pwm_r_b, pwm_g_b, pwm_b_b, led_mon_b, duty_o_b});
        exp = 32'({e_r[1], e_g[1], e_b[1], e_led[1],
                   8'(cur_duty(1, sel, int'(ch_sel_b)))});
        check_output("model_b", act, exp);
    endtask

    // One clock cycle: drive inputs while clk is low, step the model, then
    // compare both instances 1 ns after the rising edge.
    task automatic apply_stimulus(input logic r, input logic up, input logic dn,
                                  input logic show, input logic [1:0] s,
                                  input logic ca, input logic [1:0] cb);
        rst = r; btn_up = up; btn_dn = dn; btn_show = show;
        sel = s; ch_sel_a = ca; ch_sel_b = cb;
        model_edge(r, up, dn, show, s, int'(ca), int'(cb));
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic       up;
        logic       dn;
        logic [1:0] sel;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int         ea, eb;
        int         n_led, n_g1, n_g0, n_r0;
        logic       rr, ru, rd, rsh;
        logic [1:0] rs, rcb;
        logic       rca;

        checks   = 0;
        failures = 0;

        // Saturating up, then down, on R of channel 0; then a floor test on G.
        for (int i = 0; i < 27; i++) begin
            ea = (10 * (i + 1) > 255) ? 255 : 10 * (i + 1);
            eb = (7 * (i + 1) > 255) ? 255 : 7 * (i + 1);
            vecs.push_back('{1'b1, 1'b0, 2'b01, 8'(ea), 8'(eb)});
            vecs.push_back('{1'b0, 1'b0, 2'b01, 8'(ea), 8'(eb)});
        end
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'd245, 8'd182});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 8'd245, 8'd182});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'd235, 8'd175});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 8'd235, 8'd175});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 8'd0,   8'd0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 8'd10,  8'd7});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 8'd10,  8'd7});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'd0,   8'd0});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 8'd0,   8'd0});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'd0,   8'd0});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 8'd0,   8'd0});

        // Reset state
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("reset_outputs_a", 32'({pwm_r_a, pwm_g_a, pwm_b_a, led_mon_a, duty_o_a}), 32'd0);
        check_output("reset_outputs_b", 32'({pwm_r_b, pwm_g_b, pwm_b_b, led_mon_b, duty_o_b}), 32'd0);

        // Table-driven saturation vectors
        foreach (vecs[i]) begin
            apply_stimulus(1'b0, vecs[i].up, vecs[i].dn, 1'b0, vecs[i].sel, 1'b0, 2'd0);
            check_output($sformatf("table_duty_a[%0d]", i), 32'(duty_o_a), 32'(vecs[i].exp_a));
            check_output($sformatf("table_duty_b[%0d]", i), 32'(duty_o_b), 32'(vecs[i].exp_b));
        end

        // Up and down rising together cancel
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("both_press_a", 32'(duty_o_a), 32'd235);
        check_output("both_press_b", 32'(duty_o_b), 32'd175);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);

        // Up press with sel=00 is a no-op
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0);
        check_output("sel_none_duty_a", 32'(duty_o_a), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("sel_none_kept_a", 32'(duty_o_a), 32'd235);
        check_output("sel_none_kept_b", 32'(duty_o_b), 32'd175);

        // ch_sel=3 on the 3-channel instance is a no-op
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 2'd3);
        check_output("bad_ch_duty_b", 32'(duty_o_b), 32'd0);
        check_output("ch1_r_step_a", 32'(duty_o_a), 32'd10);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("bad_ch_kept_b0", 32'(duty_o_b), 32'd175);
        for (int c = 1; c < 3; c++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'(c));
            check_output($sformatf("bad_ch_kept_b%0d", c), 32'(duty_o_b), 32'd0);
        end

        // PWM shape: G of channel 1 set to 60
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1);
        end
        check_output("g1_duty_a", 32'(duty_o_a), 32'd60);
        n_led = 0; n_g1 = 0;
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1);
            n_led += int'(led_mon_a);
            n_g1  += int'(pwm_g_a[1]);
        end
        check_output("led_mon_count_pre_show", 32'(n_led), 32'd60);
        check_output("pwm_g1_count_pre_show", 32'(n_g1), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1);
        n_led = 0; n_g1 = 0; n_g0 = 0; n_r0 = 0;
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1);
            n_led += int'(led_mon_a);
            n_g1  += int'(pwm_g_a[1]);
            n_g0  += int'(pwm_g_a[0]);
            n_r0  += int'(pwm_r_a[0]);
        end
        check_output("led_mon_count_post_show", 32'(n_led), 32'd60);
        check_output("pwm_g1_count_post_show", 32'(n_g1), 32'd60);
        check_output("pwm_g0_count_post_show", 32'(n_g0), 32'd0);
        check_output("pwm_r0_count_post_show", 32'(n_r0), 32'd235);

        // Randomised traffic against the model
        rs = 2'b01; rca = 1'b0; rcb = 2'd0;
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 199) == 0);
            ru  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 3) == 0);
            rsh = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                rs  = 2'($urandom_range(0, 3));
                rca = 1'($urandom_range(0, 1));
                rcb = 2'($urandom_range(0, 3));
            end
            apply_stimulus(rr, ru, rd, rsh, rs, rca, rcb);
        end

        // Reset in the middle of a button hold
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        end
        if (!m_en[0]) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'd0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("mid_reset_outputs_a", 32'({pwm_r_a, pwm_g_a, pwm_b_a, led_mon_a, duty_o_a}), 32'd0);
        check_output("mid_reset_outputs_b", 32'({pwm_r_b, pwm_g_b, pwm_b_b, led_mon_b, duty_o_b}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        end
        check_output("held_after_reset_a", 32'(duty_o_a), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);
        check_output("repress_after_reset_a", 32'(duty_o_a), 32'd10);
        check_output("repress_after_reset_b", 32'(duty_o_b), 32'd7);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0);

`ifdef AUTO_REPEAT_EN
        // Auto-repeat: hold up for the press edge plus 40 more cycles
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1);
        for (int i = 0; i <= 40; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1);
        end
        check_output("repeat_final_a", 32'(duty_o_a), 32'd60);
        check_output("repeat_final_b", 32'(duty_o_b), 32'd42);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_bank.md
# rgb_pwm_bank

Multi-channel RGB brightness controller: holds an independent PWM duty value for each colour of CH RGB LEDs, adjusts the selected channel/colour in saturating steps on debounced button presses, and drives the PWM outputs from one shared, prescaled counter. It sits between the board-level debounce block and the RGB LED pins. It also provides a single-LED monitor output and a duty readback for the selected channel.

## Interface
- CH, 2: number of RGB LEDs, range 2..16; CSW = clog2(CH)
- DUTY_W, 8: duty and PWM counter width
- STEP, 10: increment/decrement per step, range 1..2^DUTY_W-1
- PRESC, 1: clock cycles per PWM counter tick, range ≥1
- REPEAT_DLY, 50000000: hold cycles before the first auto-repeat; used only with AUTO_REPEAT_EN
- REPEAT_PER, 10000000: cycles between auto-repeats; used only with AUTO_REPEAT_EN
- clk  in  1  system clock; the only clock domain
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  debounced level; press increases brightness
- btn_dn  in  1  debounced level; press decreases brightness
- btn_show  in  1  debounced level; press toggles output enable
- sel  in  2  colour select: 00 none, 01 R, 10 G, 11 B
- ch_sel  in  CSW  channel select; values ≥CH are ignored
- pwm_r, pwm_g, pwm_b  out  CH  registered PWM outputs, one bit per channel
- led_mon  out  1  registered raw PWM of the selected channel/colour; 0 when sel=00
- duty_o  out  DUTY_W  duty of the selected channel/colour; 0 when sel=00 or ch_sel≥CH

## Operation
- Press detection: each button is registered. A press is `btn & ~btn_q`, giving one action per rising edge. Holding a button gives no further action unless AUTO_REPEAT_EN is defined.
- Duty storage: 3×CH registers of DUTY_W bits. MAX = 2^DUTY_W-1.
- Up press: duty ← (duty > MAX-STEP) ? MAX : duty+STEP.
- Down press: duty ← (duty < STEP) ? 0 : duty-STEP.
- No wrap in either direction.
- A press applies only to the register addressed by {ch_sel, sel}. A press with sel=00 or ch_sel≥CH is a no-op.
- Up and down presses detected in the same cycle: neither is applied.
- btn_show press toggles `en`.
- PWM counter:
  - A prescaler counts 0..PRESC-1 and asserts tick at PRESC-1.
  - cnt (DUTY_W bits) increments on tick and wraps from MAX to 0.
- Raw output = (cnt < duty).
  - duty=0 gives constant 0.
  - duty=MAX gives high for MAX of every 2^DUTY_W ticks.
- pwm_* = en & raw.
- led_mon = raw of the selected register, independent of en.
- Reset: all duties 0, cnt 0, prescaler 0, en 0, all button registers 0. All outputs read 0 in the cycle after reset.
- Reset has priority over every press in the same cycle. Reset asserted mid-hold clears the held state: after release of rst, a button still held high does not produce a press.

## Timing
- A duty register updates at the first clk edge that samples the button high while btn_q=0.
- duty_o is combinational from the duty registers and selects. It shows the new value immediately after that edge.
- pwm_*/led_mon are registered from pre-edge cnt/duty/en: one cycle latency.
- A duty change takes effect within the current PWM period; there is no period-boundary shadowing.
- PWM period = PRESC × 2^DUTY_W cycles.
- en toggles at the edge detecting the show press. pwm_* follow one edge later.

## Configuration
- AUTO_REPEAT_EN defined:
  - After an up or down press, if the same button stays high and the other stays low for REPEAT_DLY further cycles, one more step is applied.
  - Further steps follow every REPEAT_PER cycles while the button is held.
  - Saturation rules apply unchanged.
  - The repeat counter clears on release, on both buttons high, on a sel/ch_sel change, and on rst.
  - btn_show never repeats.
- AUTO_REPEAT_EN undefined: repeat logic and counters are not synthesised; holding a button has no effect beyond the first press.

## Test plan
All scenarios use CH=2, DUTY_W=8, STEP=10, PRESC=1 unless noted.
- Saturation up: sel=01, ch_sel=0, 26 up presses from reset → duty_o steps 10…250, then 255. A 27th press → 255 unchanged.
- Saturation down: duty=5 (up press then set via STEP=5 build), down press → 0. A further down press → 0; no wrap to 251.
- PWM shape: G of ch1 set to 60, one show press → pwm_g[1] high for exactly 60 of every 256 cycles. pwm_g[0] stays 0. led_mon with sel=10, ch_sel=1 matches raw even before the show press.
- Simultaneous/invalid: up and dn rising in the same cycle → all duties unchanged. Up press with sel=00 or ch_sel=3 → unchanged.
- Reset mid-operation: duties nonzero, en=1, btn_up held, rst pulsed one cycle → all outputs 0 next cycle. Holding btn_up after reset gives no step; release and press again → duty 10.
- AUTO_REPEAT_EN, REPEAT_DLY=20, REPEAT_PER=5: hold btn_up 40 cycles from duty 0 → steps at the press edge, +20, +25, +30, +35, +40 cycles. Final duty 60.
